// File: rtl/axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_sram_slave
// Description : AXI4 slave backed by an on-chip array of DATA_WIDTH words.
//               Independent write (AW/W/B) and read (AR/R) engines, each with
//               one outstanding transaction. Supports byte strobes, FIXED and
//               INCR bursts, SLVERR for illegal requests or w_last mismatch,
//               and DECERR for beats whose word index is outside the array.
//
// Ports       : clk                 - clock
//               rst                 - asynchronous reset, active low
//               aw_* / w_* / b_*    - AXI4 write address, data and response
//               ar_* / r_*          - AXI4 read address and data
//               All outputs are driven straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_sram_slave #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 64,
    parameter int ID_WIDTH      = 1,
    parameter int MEM_DEPTH     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address channel
    input  logic [ID_WIDTH-1:0]       aw_id,
    input  logic [ADDRESS_WIDTH-1:0]  aw_addr,
    input  logic [7:0]                aw_len,
    input  logic [2:0]                aw_size,
    input  logic [1:0]                aw_burst,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH/8-1:0]   w_strb,
    input  logic                      w_last,
    input  logic                      w_valid,
    output logic                      w_ready,
    // write response channel
    output logic [ID_WIDTH-1:0]       b_id,
    output logic [1:0]                b_resp,
    output logic                      b_valid,
    input  logic                      b_ready,
    // read address channel
    input  logic [ID_WIDTH-1:0]       ar_id,
    input  logic [ADDRESS_WIDTH-1:0]  ar_addr,
    input  logic [7:0]                ar_len,
    input  logic [2:0]                ar_size,
    input  logic [1:0]                ar_burst,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    // read data channel
    output logic [ID_WIDTH-1:0]       r_id,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic                      r_valid,
    input  logic                      r_ready
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int c_MEM_AW   = $clog2(MEM_DEPTH);
    // One spare bit above the full word index so INCR stepping past the top
    // of the address space can never wrap back into the array.
    localparam int c_IDX_W    = ADDRESS_WIDTH - c_ADDR_LSB + 1;

    localparam logic [c_IDX_W-1:0] c_DEPTH   = c_IDX_W'(MEM_DEPTH);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [2:0]         c_SIZE    = 3'(c_ADDR_LSB);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write engine state
    // ------------------------------------------------------------------
    logic [1:0]          r_wstate;
    logic                r_aw_ready;
    logic                r_w_ready;
    logic                r_b_valid;
    logic [ID_WIDTH-1:0] r_b_id;
    logic [1:0]          r_b_resp;
    logic [ID_WIDTH-1:0] r_w_id;
    logic [c_IDX_W-1:0]  r_w_idx;
    logic [7:0]          r_w_len;
    logic [7:0]          r_w_cnt;
    logic                r_w_fixed;
    logic                r_w_illegal;
    logic                r_w_decerr;
    logic                r_w_lasterr;

    logic [c_IDX_W-1:0]  w_aw_idx;
    logic                w_aw_legal;
    logic                w_w_hs;
    logic                w_w_in_range;
    logic                w_w_final;
    logic                w_w_last_err;
    logic                w_mem_we;

    assign w_aw_idx     = {1'b0, aw_addr[ADDRESS_WIDTH-1:c_ADDR_LSB]};
    assign w_aw_legal   = ((aw_burst == c_BURST_FIXED) || (aw_burst == c_BURST_INCR))
                          && (aw_size == c_SIZE);
    assign w_w_hs       = (r_wstate == c_W_DATA) && w_valid && r_w_ready;
    assign w_w_in_range = (r_w_idx < c_DEPTH);
    // The slave counts beats itself; w_last is only checked, never trusted.
    assign w_w_final    = (r_w_cnt == r_w_len);
    assign w_w_last_err = (w_last != w_w_final);
    assign w_mem_we     = w_w_hs && !r_w_illegal && w_w_in_range;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (w_strb[i]) begin
                    r_mem[r_w_idx[c_MEM_AW-1:0]][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate    <= c_W_IDLE;
            r_aw_ready  <= 1'b0;
            r_w_ready   <= 1'b0;
            r_b_valid   <= 1'b0;
            r_b_id      <= '0;
            r_b_resp    <= '0;
            r_w_id      <= '0;
            r_w_idx     <= '0;
            r_w_len     <= '0;
            r_w_cnt     <= '0;
            r_w_fixed   <= 1'b0;
            r_w_illegal <= 1'b0;
            r_w_decerr  <= 1'b0;
            r_w_lasterr <= 1'b0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    // aw_ready comes up on the first edge out of reset.
                    r_aw_ready <= 1'b1;
                    if (aw_valid && r_aw_ready) begin
                        r_aw_ready  <= 1'b0;
                        r_w_ready   <= 1'b1;
                        r_w_id      <= aw_id;
                        r_w_idx     <= w_aw_idx;
                        r_w_len     <= aw_len;
                        r_w_cnt     <= '0;
                        r_w_fixed   <= (aw_burst == c_BURST_FIXED);
                        r_w_illegal <= !w_aw_legal;
                        r_w_decerr  <= 1'b0;
                        r_w_lasterr <= 1'b0;
                        r_wstate    <= c_W_DATA;
                    end
                end
                c_W_DATA: begin
                    if (w_w_hs) begin
                        if (!w_w_in_range) begin
                            r_w_decerr <= 1'b1;
                        end
                        if (w_w_last_err) begin
                            r_w_lasterr <= 1'b1;
                        end
                        if (w_w_final) begin
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_b_id    <= r_w_id;
                            // Sticky flags do not yet include this beat's errors.
                            if (r_w_illegal || r_w_lasterr || w_w_last_err) begin
                                r_b_resp <= c_RESP_SLVERR;
                            end else if (r_w_decerr || !w_w_in_range) begin
                                r_b_resp <= c_RESP_DECERR;
                            end else begin
                                r_b_resp <= c_RESP_OKAY;
                            end
                            r_wstate <= c_W_RESP;
                        end else begin
                            r_w_cnt <= r_w_cnt + 8'd1;
                            if (!r_w_fixed) begin
                                r_w_idx <= r_w_idx + c_IDX_ONE;
                            end
                        end
                    end
                end
                c_W_RESP: begin
                    if (b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wstate   <= c_W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= c_W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read engine state
    // ------------------------------------------------------------------
    logic [0:0]            r_rstate;
    logic                  r_ar_ready;
    logic                  r_r_valid;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [1:0]            r_r_resp;
    logic                  r_r_last;
    logic [ID_WIDTH-1:0]   r_r_id;
    logic [c_IDX_W-1:0]    r_r_idx;      // index of the next beat to load
    logic [7:0]            r_r_len;
    logic [7:0]            r_r_cnt;      // number of the beat currently presented
    logic                  r_r_fixed;
    logic                  r_r_illegal;

    logic [c_IDX_W-1:0]    w_ar_idx;
    logic                  w_ar_legal;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_rd_illegal;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;

    assign w_ar_idx   = {1'b0, ar_addr[ADDRESS_WIDTH-1:c_ADDR_LSB]};
    assign w_ar_legal = ((ar_burst == c_BURST_FIXED) || (ar_burst == c_BURST_INCR))
                        && (ar_size == c_SIZE);

    // In idle the first beat is fetched straight from the AR request so it
    // can be presented on the edge after the handshake.
    assign w_rd_idx      = (r_rstate == c_R_IDLE) ? w_ar_idx : r_r_idx;
    assign w_rd_illegal  = (r_rstate == c_R_IDLE) ? !w_ar_legal : r_r_illegal;
    assign w_rd_in_range = (w_rd_idx < c_DEPTH);
    // Combinational array read: a write at the same edge lands after this
    // value is captured, so the read sees the old word.
    assign w_rd_word     = r_mem[w_rd_idx[c_MEM_AW-1:0]];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_RESP_OKAY;
        if (w_rd_illegal) begin
            w_rd_resp = c_RESP_SLVERR;
        end else if (!w_rd_in_range) begin
            w_rd_resp = c_RESP_DECERR;
        end else begin
            w_rd_data = w_rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate    <= c_R_IDLE;
            r_ar_ready  <= 1'b0;
            r_r_valid   <= 1'b0;
            r_r_data    <= '0;
            r_r_resp    <= '0;
            r_r_last    <= 1'b0;
            r_r_id      <= '0;
            r_r_idx     <= '0;
            r_r_len     <= '0;
            r_r_cnt     <= '0;
            r_r_fixed   <= 1'b0;
            r_r_illegal <= 1'b0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    r_ar_ready <= 1'b1;
                    if (ar_valid && r_ar_ready) begin
                        r_ar_ready  <= 1'b0;
                        r_r_valid   <= 1'b1;
                        r_r_data    <= w_rd_data;
                        r_r_resp    <= w_rd_resp;
                        r_r_last    <= (ar_len == 8'd0);
                        r_r_id      <= ar_id;
                        r_r_len     <= ar_len;
                        r_r_cnt     <= '0;
                        r_r_fixed   <= (ar_burst == c_BURST_FIXED);
                        r_r_illegal <= !w_ar_legal;
                        r_r_idx     <= (ar_burst == c_BURST_FIXED) ? w_ar_idx
                                                                   : w_ar_idx + c_IDX_ONE;
                        r_rstate    <= c_R_DATA;
                    end
                end
                c_R_DATA: begin
                    // r_valid is always high here, so r_ready alone is the handshake.
                    if (r_ready) begin
                        if (r_r_last) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rstate   <= c_R_IDLE;
                        end else begin
                            r_r_data <= w_rd_data;
                            r_r_resp <= w_rd_resp;
                            r_r_last <= ((r_r_cnt + 8'd1) == r_r_len);
                            r_r_cnt  <= r_r_cnt + 8'd1;
                            if (!r_r_fixed) begin
                                r_r_idx <= r_r_idx + c_IDX_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_rstate <= c_R_IDLE;
                end
            endcase
        end
    end

    // Byte-lane address bits carry no meaning for full-width beats.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{aw_addr[c_ADDR_LSB-1:0], ar_addr[c_ADDR_LSB-1:0]};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign aw_ready = r_aw_ready;
    assign w_ready  = r_w_ready;
    assign b_id     = r_b_id;
    assign b_resp   = r_b_resp;
    assign b_valid  = r_b_valid;
    assign ar_ready = r_ar_ready;
    assign r_id     = r_r_id;
    assign r_data   = r_r_data;
    assign r_resp   = r_r_resp;
    assign r_last   = r_r_last;
    assign r_valid  = r_r_valid;

endmodule
`default_nettype wire
